// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the front-panel button debouncer.
// The BUTTON_LONG_PRESS_EN build option lives in debounce_channel; nothing here depends on it.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int CLK_HZ        = 50000000;
   localparam int CYCLES_PER_MS = CLK_HZ / 1000;

   function automatic int ms_to_cycles(input int ms);
      return ms * CYCLES_PER_MS;
   endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between board pins and the timing/display logic.
// The master side drives the raw pins; the slave side is the debouncer.
interface button_debouncer_if #(
   parameter int NUM_BUTTONS = 4
);
   logic [NUM_BUTTONS-1:0] buttons_in;
   logic [NUM_BUTTONS-1:0] pressed;
   logic [NUM_BUTTONS-1:0] press_pulse;
   logic [NUM_BUTTONS-1:0] release_pulse;
   logic [NUM_BUTTONS-1:0] toggle;
   logic [NUM_BUTTONS-1:0] long_press;

   modport master (
      output buttons_in,
      input  pressed, press_pulse, release_pulse, toggle, long_press
   );

   modport slave (
      input  buttons_in,
      output pressed, press_pulse, release_pulse, toggle, long_press
   );
endinterface

// File: rtl/button_debouncer_debounce_channel.sv
// One button: 2-flop synchroniser, registered detect, debounce FSM and outputs.
// Define BUTTON_LONG_PRESS_EN to add the hold counter and long_press pulse.
module debounce_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int ACTIVE_LOW        = 1,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button_in,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic toggle,
   output logic long_press
);
   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic              INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
      $error("debounce_channel: LONG_PRESS_CYCLES must be at least 1");
   end

   logic             sync1_r, sync2_r, act_r;
   btn_state_e       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             pressed_r, pressed_s;
   logic             press_pulse_r, press_pulse_s;
   logic             release_pulse_r, release_pulse_s;
   logic             toggle_r, toggle_s;

   // Synchronise the raw pin, then register it as a polarity-normalised level
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= INACTIVE;
         sync2_r <= INACTIVE;
         act_r   <= 1'b0;
      end else begin
         sync1_r <= button_in;
         sync2_r <= sync1_r;
         act_r   <= sync2_r ^ INACTIVE;
      end
   end

   // Debounce next-state and registered-output decode
   always_comb begin
      state_s         = state_r;
      cnt_s           = cnt_r;
      pressed_s       = pressed_r;
      toggle_s        = toggle_r;
      press_pulse_s   = 1'b0;
      release_pulse_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (act_r) begin
               state_s = PRESS_WAIT;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         PRESS_WAIT: begin
            if (!act_r) begin
               state_s = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               state_s       = PRESSED;
               press_pulse_s = 1'b1;
               toggle_s      = ~toggle_r;
               pressed_s     = 1'b1;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!act_r) begin
               state_s = RELEASE_WAIT;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = PRESSED;
            end
         end
         RELEASE_WAIT: begin
            if (act_r) begin
               state_s = PRESSED;
            end else if (cnt_r == CNT_LAST) begin
               state_s         = IDLE;
               release_pulse_s = 1'b1;
               pressed_s       = 1'b0;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s   = IDLE;
            cnt_s     = {CNT_W{1'b0}};
            pressed_s = 1'b0;
         end
      endcase
   end

   // FSM state, counter and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= IDLE;
         cnt_r           <= {CNT_W{1'b0}};
         pressed_r       <= 1'b0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         toggle_r        <= 1'b0;
      end else begin
         state_r         <= state_s;
         cnt_r           <= cnt_s;
         pressed_r       <= pressed_s;
         press_pulse_r   <= press_pulse_s;
         release_pulse_r <= release_pulse_s;
         toggle_r        <= toggle_s;
      end
   end

   assign pressed       = pressed_r;
   assign press_pulse   = press_pulse_r;
   assign release_pulse = release_pulse_r;
   assign toggle        = toggle_r;

`ifdef BUTTON_LONG_PRESS_EN
   localparam int                HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

   logic [HOLD_W-1:0] hold_r, hold_s;
   logic              long_press_r, long_press_s;

   // Hold counter runs only while PRESSED and parks at HOLD_SAT so it pulses once
   always_comb begin
      hold_s       = hold_r;
      long_press_s = 1'b0;
      case (state_r)
         IDLE:         hold_s = {HOLD_W{1'b0}};
         PRESS_WAIT:   hold_s = {HOLD_W{1'b0}};
         PRESSED: begin
            long_press_s = (hold_r == HOLD_LAST);
            if (hold_r != HOLD_SAT) begin
               hold_s = hold_r + HOLD_W'(1);
            end else begin
               hold_s = hold_r;
            end
         end
         RELEASE_WAIT: hold_s = hold_r;
         default:      hold_s = {HOLD_W{1'b0}};
      endcase
   end

   // Hold counter and long-press pulse registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_r       <= {HOLD_W{1'b0}};
         long_press_r <= 1'b0;
      end else begin
         hold_r       <= hold_s;
         long_press_r <= long_press_s;
      end
   end

   assign long_press = long_press_r;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Front-panel button conditioner: one independent debounce channel per button.
// Optional long-press detection is enabled with BUTTON_LONG_PRESS_EN.
module button_debouncer
   import btn_pkg::*;
#(
   parameter int NUM_BUTTONS       = 4,
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int ACTIVE_LOW        = 1,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input logic              clock,
   input logic              reset_n,
   button_debouncer_if.slave bus
);
   if (NUM_BUTTONS < 1) begin : g_bad_num
      $error("button_debouncer: NUM_BUTTONS must be at least 1");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
   end

   logic [NUM_BUTTONS-1:0] pressed_s;
   logic [NUM_BUTTONS-1:0] press_pulse_s;
   logic [NUM_BUTTONS-1:0] release_pulse_s;
   logic [NUM_BUTTONS-1:0] toggle_s;
   logic [NUM_BUTTONS-1:0] long_press_s;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .ACTIVE_LOW        (ACTIVE_LOW),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
      ) u_channel (
         .clock         (clock),
         .reset_n       (reset_n),
         .button_in     (bus.buttons_in[g]),
         .pressed       (pressed_s[g]),
         .press_pulse   (press_pulse_s[g]),
         .release_pulse (release_pulse_s[g]),
         .toggle        (toggle_s[g]),
         .long_press    (long_press_s[g])
      );
   end

   assign bus.pressed       = pressed_s;
   assign bus.press_pulse   = press_pulse_s;
   assign bus.release_pulse = release_pulse_s;
   assign bus.toggle        = toggle_s;
   assign bus.long_press    = long_press_s;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: 4 active-low buttons, 8-cycle debounce, 32-cycle long press.
// Inputs change and outputs are sampled on the falling edge; edge 0 is the next rising edge.
module tb_button_debouncer;
   import btn_pkg::*;

   localparam int NB = 4;
   localparam int DC = 8;
   localparam int LP = 32;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   button_debouncer_if #(.NUM_BUTTONS(NB)) bus ();

   button_debouncer #(
      .NUM_BUTTONS       (NB),
      .DEBOUNCE_CYCLES   (DC),
      .ACTIVE_LOW        (1),
      .LONG_PRESS_CYCLES (LP)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [NB-1:0] lp_exp;
      checks = 0;
      errors = 0;

      // Reset with all buttons held
      reset_n = 1'b0;
      bus.buttons_in = 4'b0000;
      step(3);
      check("rst_pressed", bus.pressed, 4'b0000);
      check("rst_press_pulse", bus.press_pulse, 4'b0000);
      check("rst_release_pulse", bus.release_pulse, 4'b0000);
      check("rst_toggle", bus.toggle, 4'b0000);
      check("rst_long_press", bus.long_press, 4'b0000);
      reset_n = 1'b1;
      for (int i = 0; i < DC + 3; i++) begin
         step(1);
         check("rst_no_early_pulse", bus.press_pulse, 4'b0000);
      end
      step(1);
      check("rst_held_pulse", bus.press_pulse, 4'b1111);
      step(1);
      check("rst_pulse_one_cycle", bus.press_pulse, 4'b0000);
      check("rst_held_pressed", bus.pressed, 4'b1111);
      check("rst_held_toggle", bus.toggle, 4'b1111);

      // Release everything, then reset mid-operation clears toggle
      bus.buttons_in = 4'b1111;
      step(DC + 3);
      check("rel_all_early", bus.release_pulse, 4'b0000);
      step(1);
      check("rel_all_pulse", bus.release_pulse, 4'b1111);
      check("rel_all_pressed", bus.pressed, 4'b0000);
      reset_n = 1'b0;
      step(1);
      check("midrst_toggle", bus.toggle, 4'b0000);
      reset_n = 1'b1;
      step(2);

      // Clean press on bit 0, held 40 cycles
      bus.buttons_in = 4'b1110;
      step(DC + 3);
      check("clean_early", bus.press_pulse, 4'b0000);
      step(1);
      check("clean_press_pulse", bus.press_pulse, 4'b0001);
      step(1);
      check("clean_pulse_one_cycle", bus.press_pulse, 4'b0000);
      check("clean_pressed", bus.pressed, 4'b0001);
      step(27);
      check("clean_hold_pressed", bus.pressed, 4'b0001);
      check("clean_toggle", bus.toggle, 4'b0001);
      check("clean_long_press_off", bus.long_press, 4'b0000);
      bus.buttons_in = 4'b1111;
      step(DC + 3);
      check("clean_rel_early", bus.release_pulse, 4'b0000);
      step(1);
      check("clean_release_pulse", bus.release_pulse, 4'b0001);
      step(1);
      check("clean_released", bus.pressed, 4'b0000);
      check("clean_rel_one_cycle", bus.release_pulse, 4'b0000);

      // Bit 1 bounces every 3 cycles for 30 cycles, then settles pressed
      for (int i = 0; i < 10; i++) begin
         bus.buttons_in = (i % 2 == 0) ? 4'b1101 : 4'b1111;
         for (int j = 0; j < 3; j++) begin
            step(1);
            check("bounce_no_pulse", bus.press_pulse, 4'b0000);
         end
      end
      bus.buttons_in = 4'b1101;
      for (int i = 0; i < DC + 3; i++) begin
         step(1);
         check("bounce_settle_early", bus.press_pulse, 4'b0000);
      end
      step(1);
      check("bounce_press_pulse", bus.press_pulse, 4'b0010);
      step(1);
      check("bounce_pressed", bus.pressed, 4'b0010);

      // 5-cycle release glitch while pressed is swallowed
      bus.buttons_in = 4'b1111;
      step(5);
      bus.buttons_in = 4'b1101;
      for (int i = 0; i < DC + 6; i++) begin
         step(1);
         check("glitch_no_release", bus.release_pulse, 4'b0000);
         check("glitch_still_pressed", bus.pressed, 4'b0010);
      end
      bus.buttons_in = 4'b1111;
      step(DC + 4);
      check("bounce_release_pulse", bus.release_pulse, 4'b0010);
      step(1);
      check("bounce_toggle", bus.toggle, 4'b0011);

      // Three press/release cycles on bit 2: toggle[2] goes 1,0,1
      for (int p = 0; p < 3; p++) begin
         bus.buttons_in = 4'b1011;
         step(DC + 5);
         check("toggle_seq", bus.toggle, (p % 2 == 0) ? 4'b0111 : 4'b0011);
         bus.buttons_in = 4'b1111;
         step(DC + 5);
         check("toggle_released", bus.pressed, 4'b0000);
      end

      // Bits 0 and 3 pressed on the same edge
      bus.buttons_in = 4'b0110;
      step(DC + 3);
      check("simul_early", bus.press_pulse, 4'b0000);
      step(1);
      check("simul_press_pulse", bus.press_pulse, 4'b1001);
      step(1);
      check("simul_one_cycle", bus.press_pulse, 4'b0000);
      check("simul_toggle", bus.toggle, 4'b1110);
      bus.buttons_in = 4'b1111;
      step(DC + 5);
      check("simul_released", bus.pressed, 4'b0000);

      // Hold bit 0 for 50 cycles: long press (if built in) 32 cycles after press_pulse
      bus.buttons_in = 4'b1110;
      step(DC + 4);
      check("long_press_pulse", bus.press_pulse, 4'b0001);
      for (int k = 1; k <= 38; k++) begin
         step(1);
`ifdef BUTTON_LONG_PRESS_EN
         lp_exp = (k == LP) ? 4'b0001 : 4'b0000;
`else
         lp_exp = 4'b0000;
`endif
         check("long_press", bus.long_press, lp_exp);
      end
      bus.buttons_in = 4'b1111;
      step(DC + 5);
      check("long_released", bus.pressed, 4'b0000);
      check("long_after_release", bus.long_press, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
